// File: rtl/fetch_instr_queue_if.sv
// Bundle of the enqueue, dequeue, flush and occupancy signals of the fetch instruction queue.
// The queue itself sits on the slave side.
`timescale 1ns/1ps
interface fetch_instr_queue_if #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEQ_W  = 2
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int DCW = $clog2(DEQ_W + 1);

    logic                          flush;
    logic                          enq_valid;
    logic                          enq_ready;
    logic [PC_W-1:0]               enq_pc;
    logic [DATA_W-1:0]             enq_inst;
    logic [DEQ_W-1:0]              deq_valid;
    logic [DEQ_W-1:0][PC_W-1:0]    deq_pc;
    logic [DEQ_W-1:0][DATA_W-1:0]  deq_inst;
    logic [DCW-1:0]                deq_cnt;
    logic [CW-1:0]                 count;
    logic                          full;
    logic                          empty;

    modport master (
        output flush, enq_valid, enq_pc, enq_inst, deq_cnt,
        input  enq_ready, deq_valid, deq_pc, deq_inst, count, full, empty
    );

    modport slave (
        input  flush, enq_valid, enq_pc, enq_inst, deq_cnt,
        output enq_ready, deq_valid, deq_pc, deq_inst, count, full, empty
    );
endinterface

// File: rtl/fetch_instr_queue.sv
// Circular {pc, inst} buffer between imem responses and a DEQ_W-wide decode.
// Exposes the DEQ_W oldest entries each cycle; flush empties it in one cycle.
`timescale 1ns/1ps
module fetch_instr_queue #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEQ_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    fetch_instr_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    entry_t                       mem [DEPTH];
    logic [AW-1:0]                head;
    logic [AW-1:0]                tail;
    logic [CW-1:0]                count;
    logic [CW-1:0]                req;
    logic [CW-1:0]                pop;
    logic                         full;
    logic                         enq_fire;
    logic [DEQ_W-1:0]             lane_vld;
    logic [DEQ_W-1:0][PC_W-1:0]   lane_pc;
    logic [DEQ_W-1:0][DATA_W-1:0] lane_inst;

    // Pop is clamped both to what is held and to the number of lanes, so a
    // consumer can never retire an entry it was not shown.
    always_comb begin
        req = CW'(bus.deq_cnt);
        if (req > CW'(DEQ_W)) req = CW'(DEQ_W);
        pop = (req > count) ? count : req;
    end

    assign full     = (count == CW'(DEPTH));
    assign enq_fire = bus.enq_valid && !full && !bus.flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop);
            tail  <= tail + AW'(enq_fire);
            count <= count + CW'(enq_fire) - pop;
        end
    end

    // Storage carries no reset; the pointers and count alone define what is live.
    always_ff @(posedge clk) begin
        if (enq_fire) mem[tail] <= '{pc: bus.enq_pc, inst: bus.enq_inst};
    end

    for (genvar k = 0; k < DEQ_W; k++) begin : g_lane
        logic [AW-1:0] idx;
        entry_t        ent;
        assign idx          = head + AW'(k);
        assign lane_vld[k]  = (count > CW'(k));
        assign ent          = lane_vld[k] ? mem[idx] : '0;
        assign lane_pc[k]   = ent.pc;
        assign lane_inst[k] = ent.inst;
    end

    assign bus.deq_valid = lane_vld;
    assign bus.deq_pc    = lane_pc;
    assign bus.deq_inst  = lane_inst;
    assign bus.count     = count;
    assign bus.full      = full;
    assign bus.empty     = (count == '0);
    assign bus.enq_ready = !full;
endmodule
